// File: rtl/word_byte_serializer_if.sv
// Handshake bundle for word_byte_serializer: 32-bit word input, byte-wide output.
// slave = serializer side, master = producer/consumer side.
interface word_byte_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/word_byte_serializer.sv
// Word FIFO feeding a 4-beat byte shifter; MSB byte first by default.
// Define SERIALIZER_LSB_FIRST_EN to emit bytes LSB first.
module word_byte_serializer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  word_byte_serializer_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_SEND  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_in_ready;
  logic [31:0]        r_shift;
  logic [1:0]         r_idx;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_out_last;

  logic               w_push;
  logic               w_pop;
  logic               w_hs;
  logic [31:0]        w_head;
  logic [31:0]        w_shift_nxt;
  logic [1:0]         w_idx_nxt;
  logic               w_out_valid_nxt;
  logic [7:0]         w_out_data_nxt;
  logic               w_out_last_nxt;

  function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] idx);
`ifdef SERIALIZER_LSB_FIRST_EN
    case (idx)
      2'd0:    lane_sel = word[7:0];
      2'd1:    lane_sel = word[15:8];
      2'd2:    lane_sel = word[23:16];
      default: lane_sel = word[31:24];
    endcase
`else
    case (idx)
      2'd0:    lane_sel = word[31:24];
      2'd1:    lane_sel = word[23:16];
      2'd2:    lane_sel = word[15:8];
      default: lane_sel = word[7:0];
    endcase
`endif
  endfunction

  assign w_head = r_mem[r_rd_ptr];
  assign w_hs   = r_out_valid && bus.out_ready;
  assign w_push = bus.in_valid && r_in_ready;
  // Refill on the final beat so consecutive words stream without a bubble.
  assign w_pop  = (r_count != '0) &&
                  ((r_state == S_EMPTY) || (w_hs && (r_idx == 2'd3)));

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CNT_W'(DEPTH));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_pop) w_state_nxt = S_SEND;
      S_SEND:  if (w_hs && (r_idx == 2'd3) && !w_pop) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Output/datapath next values; registered below so outputs hold through stalls
  always_comb begin
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    if (w_pop) begin
      w_shift_nxt     = w_head;
      w_idx_nxt       = 2'd0;
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = lane_sel(w_head, 2'd0);
      w_out_last_nxt  = 1'b0;
    end else if (w_hs) begin
      if (r_idx == 2'd3) begin
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
      end else begin
        w_idx_nxt       = r_idx + 2'd1;
        w_out_data_nxt  = lane_sel(r_shift, r_idx + 2'd1);
        w_out_last_nxt  = (r_idx == 2'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_idx       <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_count != '0) || (r_state == S_SEND);

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench for word_byte_serializer: DEPTH=2 main instance plus a DEPTH=4
// instance for simultaneous push/pop and pointer wrap.
module tb_word_byte_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  word_byte_serializer_if bus();
  word_byte_serializer_if bus4();

  word_byte_serializer #(.DEPTH(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  word_byte_serializer #(.DEPTH(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  int n4 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] lane_of(input logic [31:0] w, input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
    lane_of = w[8*i +: 8];
`else
    lane_of = w[8*(3-i) +: 8];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic queue_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(lane_of(w, i));
  endtask

  // Consume expected bytes from the main instance, checking hold/no-drop/last.
  task automatic drain(input bit toggle, input bit chk_inrdy, input int budget);
    int cyc = 0;
    int used = 0;
    bit started = 0;
    bit pv = 0;
    bit pr = 0;
    logic [7:0] pd = 8'h00;
    logic pl = 1'b0;
    while (exp_q.size() != 0 && cyc < budget) begin
      bus.out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (started) check("no_drop", 32'(bus.out_valid), 32'd1);
      if (pv && !pr) begin
        check("hold_data", 32'(bus.out_data), 32'(pd));
        check("hold_last", 32'(bus.out_last), 32'(pl));
      end
      if (chk_inrdy && used == 3) check("inrdy_full", 32'(bus.in_ready), 32'd0);
      if (chk_inrdy && used == 4) check("inrdy_rise", 32'(bus.in_ready), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        check("byte", 32'(bus.out_data), 32'(exp_q.pop_front()));
        check("last", 32'(bus.out_last), 32'(used % 4 == 3));
        used++;
        started = 1;
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
      cyc++;
      tick();
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard for the DEPTH=4 instance; sampled after inputs settle.
  always @(negedge clk) begin
    #1;
    if (bus4.out_valid && bus4.out_ready) begin
      check("d4_byte", 32'(bus4.out_data),
            (exp4_q.size() != 0) ? 32'(exp4_q.pop_front()) : 32'hFFFF_FFFF);
      check("d4_last", 32'(bus4.out_last), 32'(n4 % 4 == 3));
      n4++;
    end
  end

  initial begin
    logic [31:0] w;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus4.in_valid = 0; bus4.in_data = '0; bus4.out_ready = 0;

    // Reset values
    reset = 1;
    tick(); tick();
    reset = 0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h00);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single word, out_ready held high: latency and byte order
    bus.in_valid = 1; bus.in_data = 32'h12345678; bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    check("lat_n", 32'(bus.out_valid), 32'd0);
    tick();
    check("lat_n1", 32'(bus.out_valid), 32'd1);
    check("lat_first", 32'(bus.out_data), 32'(lane_of(32'h12345678, 0)));
    queue_word(32'h12345678);
    drain(1'b0, 1'b0, 20);
    check("w1_busy_fall", 32'(bus.busy), 32'd0);
    check("w1_valid_fall", 32'(bus.out_valid), 32'd0);

    // Stalled output on DEADBEEF
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'hDEADBEEF;
    tick();
    bus.in_valid = 0;
    queue_word(32'hDEADBEEF);
    drain(1'b1, 1'b0, 40);
    check("w2_idle", 32'(bus.out_valid), 32'd0);

    // Fill FIFO with out_ready low; a fourth word offered while full is dropped
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      w = 32'hA1A2A3A4 + 32'(i) * 32'h10101010;
      check("fill_rdy", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1; bus.in_data = w;
      tick();
      queue_word(w);
    end
    check("full_rdy", 32'(bus.in_ready), 32'd0);
    bus.in_data = 32'hD1D2D3D4;
    tick(); tick();
    check("full_hold", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 0;
    drain(1'b0, 1'b1, 40);
    check("w3_no_extra", 32'(bus.out_valid), 32'd0);
    check("w3_busy", 32'(bus.busy), 32'd0);

    // Reset mid-word with another word still buffered
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'hCAFEF00D;
    tick();
    bus.in_data = 32'h11223344;
    tick();
    bus.in_valid = 0;
    bus.out_ready = 1;
    check("cafe_b0", 32'(bus.out_data), 32'(lane_of(32'hCAFEF00D, 0)));
    tick();
    check("cafe_b1", 32'(bus.out_data), 32'(lane_of(32'hCAFEF00D, 1)));
    tick();
    reset = 1;
    tick();
    reset = 0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_last", 32'(bus.out_last), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("post_rst_quiet", 32'(bus.out_valid), 32'd0);
      tick();
    end
    bus.out_ready = 0;

    // DEPTH=4: hold count at 2 via push on the refill edge, across pointer wrap
    n4 = 0;
    for (int k = 0; k < 3; k++) begin
      w = 32'h40414243 + 32'(k) * 32'h04040404;
      check("d4_fill_rdy", 32'(bus4.in_ready), 32'd1);
      bus4.in_valid = 1; bus4.in_data = w;
      for (int i = 0; i < 4; i++) exp4_q.push_back(lane_of(w, i));
      tick();
    end
    bus4.in_valid = 0;
    check("d4_count_init", 32'(u_dut4.r_count), 32'd2);
    bus4.out_ready = 1;
    for (int k = 3; k < 8; k++) begin
      tick(); tick(); tick();
      check("d4_last_beat", 32'(bus4.out_last), 32'd1);
      w = 32'h40414243 + 32'(k) * 32'h04040404;
      bus4.in_valid = 1; bus4.in_data = w;
      for (int i = 0; i < 4; i++) exp4_q.push_back(lane_of(w, i));
      tick();
      bus4.in_valid = 0;
      check("d4_count_pp", 32'(u_dut4.r_count), 32'd2);
    end
    for (int c = 0; c < 60 && exp4_q.size() != 0; c++) tick();
    tick();
    check("d4_drained", 32'(exp4_q.size()), 32'd0);
    check("d4_bytes", 32'(n4), 32'd32);
    check("d4_idle", 32'(bus4.out_valid), 32'd0);
    check("d4_busy", 32'(bus4.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
